// File: rtl/hdb3_line_enc_if.sv
// hdb3_line_enc_if: word input handshake and P/N line output of the line encoder
interface hdb3_line_enc_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic in_valid, in_ready, outdata_P, outdata_N, out_valid;
  modport master (output in_data, in_valid, input in_ready, outdata_P, outdata_N, out_valid);
  modport slave (input in_data, in_valid, output in_ready, outdata_P, outdata_N, out_valid);
endinterface

// File: rtl/hdb3_line_enc.sv
// hdb3_line_enc: serialises words one bit per clock and line-codes them as AMI or HDB3 P/N pulses
module hdb3_line_enc #(
  parameter int DATA_W = 8,
  parameter int MODE = 1,
  parameter int LSB_FIRST = 0
) (
  input logic clk,
  input logic rst_n,
  hdb3_line_enc_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rdy_q, rdy_d;
  logic [3:0] bit_q, bit_d, usr_q, usr_d, vt_q, vt_d;
  logic p_q, p_d, n_q, n_d, ov_q, ov_d, pos_q, pos_d, odd_q, odd_d;
  logic take, busy, sub, ins_b, pulse, pol;
  always_comb begin
    take = bus.in_valid && rdy_q;
    busy = cnt_q != '0;
    cnt_d = take ? CW'(DATA_W) : cnt_q - CW'(busy);
    sh_d = take ? bus.in_data : (LSB_FIRST != 0 ? sh_q >> 1 : sh_q << 1);
    rdy_d = cnt_d <= CW'(1);
    // four fresh zeros across the window: tag the newest as V, the oldest may become B
    sub = MODE == 1 && bit_q == '0 && vt_q == '0;
    ins_b = sub && !odd_q;
    bit_d = {bit_q[2:0], busy && (LSB_FIRST != 0 ? sh_q[0] : sh_q[DATA_W-1])};
    usr_d = {usr_q[2:0], busy};
    vt_d = {vt_q[2:1], vt_q[0] || sub, 1'b0};
    pulse = bit_q[3] || ins_b || vt_q[3];
    pol = vt_q[3] ? pos_q : !pos_q;
    p_d = pulse && pol;
    n_d = pulse && !pol;
    ov_d = usr_q[3];
    pos_d = pulse ? pol : pos_q;
    odd_d = vt_q[3] ? 1'b0 : odd_q ^ (bit_q[3] || ins_b);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      sh_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      bit_q <= '0;
      usr_q <= '0;
      vt_q <= '0;
      p_q <= 1'b0;
      n_q <= 1'b0;
      ov_q <= 1'b0;
      pos_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      bit_q <= bit_d;
      usr_q <= usr_d;
      vt_q <= vt_d;
      p_q <= p_d;
      n_q <= n_d;
      ov_q <= ov_d;
      pos_q <= pos_d;
      odd_q <= odd_d;
    end
  assign bus.in_ready = rdy_q;
  assign bus.outdata_P = p_q;
  assign bus.outdata_N = n_q;
  assign bus.out_valid = ov_q;
endmodule
